ddr3_loopback_tester: RTL and testbench
=======================================

DDR3_LOOPBACK_TESTER -- requirements
Module: ddr3_loopback_tester

Interface
- REQ-001 SHALL have parameter DQ_BITWIDTH, default 16: data word width; legal values 8 or 16.
- REQ-002 SHALL have parameter ADDRESS_BITWIDTH, default 14: row/column address width.
- REQ-003 SHALL have parameter BANK_ADDRESS_BITWIDTH, default 3: bank address width.
- REQ-004 SHALL have parameter NUM_OF_TEST_DATA, default 4: words per pass; minimum 1.
- REQ-005 SHALL have parameter START_ADDRESS, default 0: first user address.
- REQ-006 SHALL have parameter ADDRESS_STRIDE, default 1: address increment per word.
- REQ-007 SHALL have parameters STATE_BITWIDTH, STATE_WRITE_DATA and STATE_READ_DATA, defaults 5, 8 and 11: controller state encoding.
- REQ-008 SHALL have parameter ERROR_COUNT_BITWIDTH, default 8: width of the error counter.
- REQ-009 SHALL have ports, with AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH:
  - clk  in  1  sole clock.
  - reset  in  1  synchronous, active-high.
  - start  in  1  begin-pass pulse.
  - pattern_sel  in  1  0 = incrementing, 1 = LFSR.
  - main_state  in  STATE_BITWIDTH  controller state.
  - data_from_ram  in  DQ_BITWIDTH  read data.
  - data_from_ram_valid  in  1  read-data strobe.
  - write_enable  out  1  write request.
  - read_enable  out  1  read request.
  - i_user_data_address  out  AW  request address.
  - data_to_ram  out  DQ_BITWIDTH  write data.
  - busy  out  1  pass in progress.
  - done  out  1  pass finished.
  - pass  out  1  pass finished with no errors.
  - error_count  out  ERROR_COUNT_BITWIDTH  mismatch count.
  - first_error_address  out  AW  address of the first mismatch.

Function
- REQ-010 SHALL implement the states IDLE, WRITE, READ, WAIT_READ and DONE.
- REQ-011 SHALL go from IDLE or DONE to WRITE on start=1, and in the same edge: address=START_ADDRESS, data=seed, write_enable=1, busy=1, done/pass/error_count/first_error_address cleared.
- REQ-012 SHALL ignore start in WRITE, READ and WAIT_READ.
- REQ-013 SHALL, in WRITE, count each cycle with main_state==STATE_WRITE_DATA as one accepted write, then advance the address by ADDRESS_STRIDE (modulo 2^AW) and the data to the next pattern word.
- REQ-014 SHALL, on the NUM_OF_TEST_DATA-th accepted write, in the same edge: clear write_enable, set read_enable=1, reload address=START_ADDRESS, reseed the expected-data generator, and enter READ.
- REQ-015 SHALL, in READ, count each cycle with main_state==STATE_READ_DATA as one issued read and advance the address; on the last issued read it SHALL clear read_enable and enter WAIT_READ, or enter DONE directly if all read data has already been received.
- REQ-016 SHALL, in READ and WAIT_READ, compare each data_from_ram_valid word, in order, against the expected generator and advance that generator.
- REQ-017 SHALL ignore valid strobes received outside READ/WAIT_READ and any strobes beyond NUM_OF_TEST_DATA.
- REQ-018 SHALL, on each mismatch, increment error_count, saturating at all-ones.
- REQ-019 SHALL, on the first mismatch only, capture first_error_address = START_ADDRESS + k*ADDRESS_STRIDE (mod 2^AW), where k is the received-word index.
- REQ-020 SHALL enter DONE from WAIT_READ when the received count equals NUM_OF_TEST_DATA, including when the final issue and the final valid occur in the same cycle.
- REQ-021 SHALL, in DONE, hold done=1, busy=0 and pass=(error_count==0).
- REQ-022 SHALL generate the incrementing pattern as word k = k mod 2^DQ_BITWIDTH, with seed 0.
- REQ-023 SHALL generate the LFSR pattern with seed 1 and next = (x>>1) XOR (x[0] ? POLY : 0), where POLY = 0xB400 for DQ_BITWIDTH 16 and 0xB8 for DQ_BITWIDTH 8.
- REQ-024 SHALL sample pattern_sel only on the start edge.

Reset
- REQ-025 SHALL, on reset, force state IDLE and drive every output to 0 on the next clk edge, including when reset is asserted mid-pass.
- REQ-026 SHALL clear all counters and generators on reset, so that a subsequent start runs a clean pass.

Configuration
- REQ-027 SHALL compile the LFSR pattern generator only when the macro DDR3_LOOPBACK_LFSR_EN is defined.
- REQ-028 SHALL, without DDR3_LOOPBACK_LFSR_EN, ignore pattern_sel and always use the incrementing pattern, while keeping the same port list.

Verification
- REQ-029 SHALL cover: default parameters, pattern_sel=0, memory model echoing writes 2 cycles late -> writes 0..3 at addresses 0..3, reads from 0..3, done=1, pass=1, error_count=0.
- REQ-030 SHALL cover: read word 2 returned as 0x0006 instead of 0x0002 -> error_count=1, first_error_address=2, pass=0.
- REQ-031 SHALL cover: AW=17, START_ADDRESS=0x1FFF0, ADDRESS_STRIDE=8 -> address sequence 0x1FFF0, 0x1FFF8, 0x00000, 0x00008 for both writes and reads.
- REQ-032 SHALL cover: DDR3_LOOPBACK_LFSR_EN defined, pattern_sel=1 -> data_to_ram sequence 0x0001, 0xB400, 0x5A00, 0x2D00 and pass=1.
- REQ-033 SHALL cover: reset asserted mid-READ -> all outputs 0 on the next edge; a following start repeats the REQ-029 result.
- REQ-034 SHALL cover: NUM_OF_TEST_DATA=300 with every read word inverted -> error_count saturates at 255, first_error_address=0; and, without the macro, pattern_sel=1 yields incrementing data.

Source files
------------

// File: rtl/ddr3_loopback_tester.sv
// Writes a test pattern through a DDR3 controller user port, reads it back and counts mismatches.
// Defining DDR3_LOOPBACK_LFSR_EN compiles in the LFSR pattern generator selected by pattern_sel.
module ddr3_loopback_tester #(
    parameter int DQ_BITWIDTH           = 16,
    parameter int ADDRESS_BITWIDTH      = 14,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int NUM_OF_TEST_DATA      = 4,
    parameter int START_ADDRESS         = 0,
    parameter int ADDRESS_STRIDE        = 1,
    parameter int STATE_BITWIDTH        = 5,
    parameter int STATE_WRITE_DATA      = 8,
    parameter int STATE_READ_DATA       = 11,
    parameter int ERROR_COUNT_BITWIDTH  = 8
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              start,
    input  logic                                              pattern_sel,
    input  logic [STATE_BITWIDTH-1:0]                         main_state,
    input  logic [DQ_BITWIDTH-1:0]                            data_from_ram,
    input  logic                                              data_from_ram_valid,
    output logic                                              write_enable,
    output logic                                              read_enable,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
    output logic [DQ_BITWIDTH-1:0]                            data_to_ram,
    output logic                                              busy,
    output logic                                              done,
    output logic                                              pass,
    output logic [ERROR_COUNT_BITWIDTH-1:0]                   error_count,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address
);
    localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
    localparam int DW = DQ_BITWIDTH;
    localparam int EW = ERROR_COUNT_BITWIDTH;
    localparam int CW = $clog2(NUM_OF_TEST_DATA + 1);
    localparam logic [CW-1:0] LAST_IDX   = CW'(NUM_OF_TEST_DATA - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(NUM_OF_TEST_DATA);
    localparam logic [AW-1:0] START      = AW'(START_ADDRESS);
    localparam logic [AW-1:0] STRIDE     = AW'(ADDRESS_STRIDE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_WAIT_READ,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   rx_addr_q, rx_addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [DW-1:0]   exp_q, exp_d;
    logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [EW-1:0]   err_q, err_d;
    logic [AW-1:0]   first_err_q, first_err_d;
    logic            err_seen_q, err_seen_d;
    logic            we_q, we_d;
    logic            re_q, re_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;

    logic            start_ok;
    logic [DW-1:0]   data_step;
    logic [DW-1:0]   exp_step;
    logic [DW-1:0]   seed_new;
    logic [DW-1:0]   seed_cur;

    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);

`ifdef DDR3_LOOPBACK_LFSR_EN
    localparam logic [DW-1:0] POLY = (DW == 16) ? DW'(16'hB400) : DW'(8'hB8);
    logic lfsr_mode_q, lfsr_mode_d;

    assign data_step = lfsr_mode_q ? ((data_q >> 1) ^ (data_q[0] ? POLY : '0)) : data_q + 1'b1;
    assign exp_step  = lfsr_mode_q ? ((exp_q >> 1) ^ (exp_q[0] ? POLY : '0)) : exp_q + 1'b1;
    assign seed_new  = pattern_sel ? DW'(1) : '0;
    assign seed_cur  = lfsr_mode_q ? DW'(1) : '0;

    // Pattern choice is frozen for the whole pass at the start edge.
    always_comb begin
        lfsr_mode_d = lfsr_mode_q;
        if (start_ok) lfsr_mode_d = pattern_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) lfsr_mode_q <= 1'b0;
        else       lfsr_mode_q <= lfsr_mode_d;
    end
`else
    logic unused_pattern_sel;

    assign unused_pattern_sel = pattern_sel;
    assign data_step          = data_q + 1'b1;
    assign exp_step           = exp_q + 1'b1;
    assign seed_new           = '0;
    assign seed_cur           = '0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rx_addr_d   = rx_addr_q;
        data_d      = data_q;
        exp_d       = exp_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        err_d       = err_q;
        first_err_d = first_err_q;
        err_seen_d  = err_seen_q;
        we_d        = we_q;
        re_d        = re_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;

        // Read-data checking runs alongside read issue; strobes past the last word are dropped.
        if ((state_q == ST_READ || state_q == ST_WAIT_READ) && data_from_ram_valid
                && rx_cnt_q != COUNT_FULL) begin
            rx_cnt_d  = rx_cnt_q + CW'(1);
            rx_addr_d = rx_addr_q + STRIDE;
            exp_d     = exp_step;
            if (data_from_ram != exp_q) begin
                if (err_q != '1) err_d = err_q + EW'(1);
                if (!err_seen_q) begin
                    err_seen_d  = 1'b1;
                    first_err_d = rx_addr_q;
                end
            end
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_WRITE;
                    addr_d      = START;
                    rx_addr_d   = START;
                    data_d      = seed_new;
                    exp_d       = seed_new;
                    wr_cnt_d    = '0;
                    rd_cnt_d    = '0;
                    rx_cnt_d    = '0;
                    err_d       = '0;
                    first_err_d = '0;
                    err_seen_d  = 1'b0;
                    we_d        = 1'b1;
                    re_d        = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                end
            end
            ST_WRITE: begin
                if (main_state == STATE_BITWIDTH'(STATE_WRITE_DATA)) begin
                    wr_cnt_d = wr_cnt_q + CW'(1);
                    data_d   = data_step;
                    if (wr_cnt_q == LAST_IDX) begin
                        state_d   = ST_READ;
                        we_d      = 1'b0;
                        re_d      = 1'b1;
                        addr_d    = START;
                        rx_addr_d = START;
                        exp_d     = seed_cur;
                    end else begin
                        addr_d = addr_q + STRIDE;
                    end
                end
            end
            ST_READ: begin
                if (main_state == STATE_BITWIDTH'(STATE_READ_DATA)) begin
                    rd_cnt_d = rd_cnt_q + CW'(1);
                    addr_d   = addr_q + STRIDE;
                    if (rd_cnt_q == LAST_IDX) begin
                        re_d = 1'b0;
                        if (rx_cnt_d == COUNT_FULL) begin
                            state_d = ST_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (err_d == '0);
                        end else begin
                            state_d = ST_WAIT_READ;
                        end
                    end
                end
            end
            ST_WAIT_READ: begin
                if (rx_cnt_d == COUNT_FULL) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rx_addr_q   <= '0;
            data_q      <= '0;
            exp_q       <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            err_q       <= '0;
            first_err_q <= '0;
            err_seen_q  <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rx_addr_q   <= rx_addr_d;
            data_q      <= data_d;
            exp_q       <= exp_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            err_q       <= err_d;
            first_err_q <= first_err_d;
            err_seen_q  <= err_seen_d;
            we_q        <= we_d;
            re_q        <= re_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign write_enable        = we_q;
    assign read_enable         = re_q;
    assign i_user_data_address = addr_q;
    assign data_to_ram         = data_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign pass                = pass_q;
    assign error_count         = err_q;
    assign first_error_address = first_err_q;

endmodule

// File: tb/tb_ddr3_loopback_tester.sv
// Bench for ddr3_loopback_tester: three instances (default, wrapping address, 300-word) share one
// memory model; a scoreboard checks every write/read request and a vector table checks pass results.
`timescale 1ns/1ps
module tb_ddr3_loopback_tester;
    localparam int AW = 17;
    localparam int DW = 16;
    localparam int EW = 8;
    localparam logic [4:0] ST_WR = 5'd8;
    localparam logic [4:0] ST_RD = 5'd11;
`ifdef DDR3_LOOPBACK_LFSR_EN
    localparam bit LFSR_BUILT = 1'b1;
`else
    localparam bit LFSR_BUILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    start_v;
    logic          pattern_sel;
    logic [4:0]    main_state;
    logic [DW-1:0] data_from_ram;
    logic          data_from_ram_valid;

    logic [2:0]          we_v, re_v, busy_v, done_v, pass_v;
    logic [2:0][AW-1:0]  addr_v, fea_v;
    logic [2:0][DW-1:0]  dout_v;
    logic [2:0][EW-1:0]  ec_v;

    always #5 clk = ~clk;

    ddr3_loopback_tester u_dut_base (
        .clk(clk), .reset(reset), .start(start_v[0]), .pattern_sel(pattern_sel),
        .main_state(main_state), .data_from_ram(data_from_ram),
        .data_from_ram_valid(data_from_ram_valid),
        .write_enable(we_v[0]), .read_enable(re_v[0]), .i_user_data_address(addr_v[0]),
        .data_to_ram(dout_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .error_count(ec_v[0]), .first_error_address(fea_v[0])
    );

    ddr3_loopback_tester #(.START_ADDRESS(32'h1FFF0), .ADDRESS_STRIDE(8)) u_dut_wrap (
        .clk(clk), .reset(reset), .start(start_v[1]), .pattern_sel(pattern_sel),
        .main_state(main_state), .data_from_ram(data_from_ram),
        .data_from_ram_valid(data_from_ram_valid),
        .write_enable(we_v[1]), .read_enable(re_v[1]), .i_user_data_address(addr_v[1]),
        .data_to_ram(dout_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .error_count(ec_v[1]), .first_error_address(fea_v[1])
    );

    ddr3_loopback_tester #(.NUM_OF_TEST_DATA(300)) u_dut_sat (
        .clk(clk), .reset(reset), .start(start_v[2]), .pattern_sel(pattern_sel),
        .main_state(main_state), .data_from_ram(data_from_ram),
        .data_from_ram_valid(data_from_ram_valid),
        .write_enable(we_v[2]), .read_enable(re_v[2]), .i_user_data_address(addr_v[2]),
        .data_to_ram(dout_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .error_count(ec_v[2]), .first_error_address(fea_v[2])
    );

    typedef struct {
        int            sel;
        bit            psel;
        int            lat;
        int            bad_idx;
        logic [DW-1:0] bad_val;
        bit            invert;
        logic [EW-1:0] exp_ec;
        logic [AW-1:0] exp_fea;
        bit            exp_pass;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    vec_t          tbl[7];
    wr_t           wr_q[$];
    logic [AW-1:0] rd_q[$];
    logic [DW-1:0] mem[int];
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int n_of(input int s);
        return (s == 2) ? 300 : 4;
    endfunction

    function automatic int start_of(input int s);
        return (s == 1) ? 32'h1FFF0 : 0;
    endfunction

    function automatic int stride_of(input int s);
        return (s == 1) ? 8 : 1;
    endfunction

    function automatic logic [DW-1:0] model_word(input int k, input bit lfsr);
        logic [DW-1:0] x;
        if (lfsr && LFSR_BUILT) begin
            x = 16'h0001;
            for (int i = 0; i < k; i++) x = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
        end else begin
            x = DW'(k);
        end
        return x;
    endfunction

    function automatic logic [63:0] outs_of(input int s);
        return {1'b0, we_v[s], re_v[s], busy_v[s], done_v[s], pass_v[s],
                ec_v[s], fea_v[s], addr_v[s], dout_v[s]};
    endfunction

    task automatic run_pass(input int idx, input vec_t v);
        int            n;
        int            k_rd;
        int            cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] rdata;
        logic [EW-1:0] ec_hold;
        logic          pv[2];
        logic [DW-1:0] pd[2];
        wr_t           w;

        n = n_of(v.sel);
        wr_q.delete();
        rd_q.delete();
        mem.delete();
        for (int k = 0; k < n; k++) begin
            a = AW'(start_of(v.sel) + k * stride_of(v.sel));
            wr_q.push_back('{a, model_word(k, v.psel)});
            rd_q.push_back(a);
        end
        pv[0] = 1'b0; pv[1] = 1'b0; pd[0] = '0; pd[1] = '0;
        k_rd = 0;

        @(negedge clk);
        pattern_sel = v.psel;
        start_v     = 3'b001 << v.sel;
        for (cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                pattern_sel = ~v.psel;
                check($sformatf("v%0d_busy_after_start", idx), {62'd0, busy_v[v.sel], we_v[v.sel]}, 64'h3);
            end
            if (done_v[v.sel]) break;
            // Stray start pulses mid-pass must have no effect.
            start_v = (cyc % 5 == 3) ? (3'b001 << v.sel) : 3'b000;
            data_from_ram_valid = 1'b0;
            if (v.lat != 0) begin
                data_from_ram_valid = pv[1];
                data_from_ram       = pd[1];
                pv[1] = pv[0]; pd[1] = pd[0]; pv[0] = 1'b0;
            end
            main_state = 5'd0;
            if (we_v[v.sel] && $urandom_range(0, 3) != 0) begin
                main_state = ST_WR;
                if (wr_q.size() == 0) begin
                    check($sformatf("v%0d_extra_write", idx), 64'd1, 64'd0);
                end else begin
                    w = wr_q.pop_front();
                    check($sformatf("v%0d_wr_addr", idx), 64'(addr_v[v.sel]), 64'(w.addr));
                    check($sformatf("v%0d_wr_data", idx), 64'(dout_v[v.sel]), 64'(w.data));
                end
                mem[int'(addr_v[v.sel])] = dout_v[v.sel];
                $display("v%0d wr addr=%05h data=%04h", idx, addr_v[v.sel], dout_v[v.sel]);
            end else if (re_v[v.sel] && $urandom_range(0, 3) != 0) begin
                main_state = ST_RD;
                if (rd_q.size() == 0) begin
                    check($sformatf("v%0d_extra_read", idx), 64'd1, 64'd0);
                end else begin
                    a = rd_q.pop_front();
                    check($sformatf("v%0d_rd_addr", idx), 64'(addr_v[v.sel]), 64'(a));
                end
                rdata = mem.exists(int'(addr_v[v.sel])) ? mem[int'(addr_v[v.sel])] : '0;
                if (v.invert) rdata = ~rdata;
                if (k_rd == v.bad_idx) rdata = v.bad_val;
                k_rd++;
                if (v.lat == 0) begin
                    data_from_ram_valid = 1'b1;
                    data_from_ram       = rdata;
                end else begin
                    pv[0] = 1'b1;
                    pd[0] = rdata;
                end
                $display("v%0d rd addr=%05h data=%04h", idx, addr_v[v.sel], rdata);
            end
        end
        start_v             = 3'b000;
        main_state          = 5'd0;
        data_from_ram_valid = 1'b0;
        if (cyc >= 5000) check($sformatf("v%0d_timeout", idx), 64'd1, 64'd0);

        check($sformatf("v%0d_done_flags", idx),
              {59'd0, we_v[v.sel], re_v[v.sel], busy_v[v.sel], done_v[v.sel], pass_v[v.sel]},
              {59'd0, 4'b0001, v.exp_pass});
        check($sformatf("v%0d_error_count", idx), 64'(ec_v[v.sel]), 64'(v.exp_ec));
        check($sformatf("v%0d_first_error_address", idx), 64'(fea_v[v.sel]), 64'(v.exp_fea));
        check($sformatf("v%0d_writes_left", idx), 64'(wr_q.size()), 64'd0);
        check($sformatf("v%0d_reads_left", idx), 64'(rd_q.size()), 64'd0);

        // A strobe arriving in DONE must not be counted.
        ec_hold             = ec_v[v.sel];
        data_from_ram_valid = 1'b1;
        data_from_ram       = 16'hFFFF;
        @(negedge clk);
        data_from_ram_valid = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_ec_after_done_strobe", idx), 64'(ec_v[v.sel]), 64'(ec_hold));
        $display("v%0d end: pass=%0b errors=%0d first=%05h", idx, pass_v[v.sel], ec_v[v.sel], fea_v[v.sel]);
    endtask

    task automatic reset_mid_read();
        int nrd;
        int cyc;
        nrd = 0;
        @(negedge clk);
        pattern_sel = 1'b0;
        start_v     = 3'b001;
        for (cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            start_v    = 3'b000;
            main_state = 5'd0;
            if (re_v[0] && nrd == 2) begin
                reset = 1'b1;
                break;
            end
            if (we_v[0]) begin
                main_state = ST_WR;
            end else if (re_v[0]) begin
                main_state = ST_RD;
                nrd++;
            end
        end
        if (cyc >= 200) check("mid_read_reach_timeout", 64'd1, 64'd0);
        @(negedge clk);
        check("outs_after_mid_read_reset", outs_of(0), 64'd0);
        reset = 1'b0;
        $display("reset asserted mid-read after %0d reads", nrd);
    endtask

    initial begin
        tbl[0] = '{0, 1'b0, 2, -1, 16'h0000, 1'b0, 8'd0,   17'h00000, 1'b1};
        tbl[1] = '{0, 1'b0, 2,  2, 16'h0006, 1'b0, 8'd1,   17'h00002, 1'b0};
        tbl[2] = '{1, 1'b0, 2, -1, 16'h0000, 1'b0, 8'd0,   17'h00000, 1'b1};
        tbl[3] = '{0, 1'b1, 2, -1, 16'h0000, 1'b0, 8'd0,   17'h00000, 1'b1};
        tbl[4] = '{0, 1'b0, 0,  3, 16'h1234, 1'b0, 8'd1,   17'h00003, 1'b0};
        tbl[5] = '{1, 1'b0, 2,  1, 16'h0000, 1'b0, 8'd1,   17'h1FFF8, 1'b0};
        tbl[6] = '{2, 1'b0, 2, -1, 16'h0000, 1'b1, 8'd255, 17'h00000, 1'b0};

        reset               = 1'b1;
        start_v             = 3'b000;
        pattern_sel         = 1'b0;
        main_state          = 5'd0;
        data_from_ram       = '0;
        data_from_ram_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs_base", outs_of(0), 64'd0);
        check("reset_outs_wrap", outs_of(1), 64'd0);
        check("reset_outs_sat",  outs_of(2), 64'd0);
        reset = 1'b0;

        // Strobes while IDLE must be ignored.
        data_from_ram_valid = 1'b1;
        data_from_ram       = 16'hDEAD;
        repeat (2) @(negedge clk);
        data_from_ram_valid = 1'b0;
        @(negedge clk);
        check("idle_strobe_ignored", outs_of(0), 64'd0);

        // The LFSR words are also checked against literal values when the generator is built.
        if (LFSR_BUILT) begin
            check("lfsr_word1", 64'(model_word(1, 1'b1)), 64'h0000_0000_0000_B400);
            check("lfsr_word3", 64'(model_word(3, 1'b1)), 64'h0000_0000_0000_2D00);
        end

        for (int i = 0; i < 7; i++) run_pass(i, tbl[i]);

        reset_mid_read();
        run_pass(7, tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
